// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice.
// Walks operands LSB first, ripples carry and fixes up SLT.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_less,
  output logic             alu_add_sub,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_co,
  input  logic             alu_r
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SLT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]       state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             sum_msb_q;

  logic legal;
  logic arith;
  logic is_slt;
  logic is_last;
  logic accept;

  assign legal = (op_q == OP_AND) || (op_q == OP_OR)
              || (op_q == OP_ADD) || (op_q == OP_SUB)
              || (op_q == OP_SLT);
  assign arith   = legal && op_q[1];
  assign is_slt  = (op_q == OP_SLT);
  assign is_last = (idx_q == LAST);
  assign accept  = start
                && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign busy     = (state_q == S_RUN) || (state_q == S_SLT);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

  // Slice drive; illegal codes leave the slice idle
  always_comb begin
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_less    = 1'b0;
    alu_add_sub = 1'b0;
    alu_cin     = 1'b0;
    alu_op      = 2'b00;
    unique case (1'b1)
      (state_q == S_RUN) && legal: begin
        alu_a       = a_q[idx_q];
        alu_b       = b_q[idx_q];
        alu_add_sub = op_q[2];
        alu_op      = is_slt ? 2'b10 : op_q[1:0];
        alu_cin     = (idx_q == '0) ? op_q[2] : carry_q;
      end
      (state_q == S_SLT): begin
        alu_op      = 2'b11;
        alu_less    = sum_msb_q ^ ovf_q;
        alu_add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sum_msb_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_RUN;
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_sel;
            idx_q   <= '0;
            carry_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          result_q[idx_q] <= legal ? alu_r : 1'b0;
          carry_q         <= alu_co;
          if (is_last) begin
            cout_q    <= arith ? alu_co : 1'b0;
            ovf_q     <= arith ? (alu_cin ^ alu_co) : 1'b0;
            sum_msb_q <= alu_r;
            state_q   <= is_slt ? S_SLT : S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_SLT: begin
          result_q <= {{(WIDTH-1){1'b0}}, alu_r};
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
